// File: rtl/gray_ptr_sync_if.sv
`default_nettype none
// ============================================================================
//  Module   : gray_ptr_sync_if
//  Purpose  : Signal bundle between a foreign-domain Gray pointer source and
//             its destination-domain synchroniser (gray_ptr_sync).
//  Revision : 1.0 - initial release
// ============================================================================
interface gray_ptr_sync_if #(
    parameter int WIDTH = 6
);
    logic [WIDTH:0] gray_in;
    logic           err_clr;
    logic [WIDTH:0] gray_out;
    logic [WIDTH:0] bin_out;
    logic           upd;
    logic           valid;
    logic           err;

    // Pointer source / consumer side
    modport master (
        output gray_in, err_clr,
        input  gray_out, bin_out, upd, valid, err
    );

    // Synchroniser side
    modport slave (
        input  gray_in, err_clr,
        output gray_out, bin_out, upd, valid, err
    );
endinterface
`default_nettype wire

// File: rtl/gray_ptr_sync.sv
`default_nettype none
// ============================================================================
//  Module   : gray_ptr_sync
//  Purpose  : STAGES-deep synchroniser for a WIDTH+1 bit Gray FIFO pointer,
//             with registered binary decode, one-cycle update strobe and a
//             post-reset valid flag.
//             Optional multi-bit-jump checker enabled by defining the macro
//             GRAY_PTR_SYNC_CHECK_EN; without it err is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module gray_ptr_sync #(
    parameter int WIDTH  = 6,
    parameter int STAGES = 2
) (
    input  logic              clk,
    input  logic              rstn,
    gray_ptr_sync_if.slave    bus
);

    localparam int c_PW = WIDTH + 1;

    // Synchroniser depth outside 2..4 is rejected at elaboration
    generate
        if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
            $error("gray_ptr_sync: STAGES must be in the range 2..4");
        end
    endgenerate

    logic [c_PW-1:0] r_sync [STAGES];
    logic [c_PW-1:0] w_gray_out;
    logic [c_PW-1:0] w_bin;
    logic [c_PW-1:0] r_gprev;
    logic [c_PW-1:0] r_bin;
    logic            r_upd;
    logic [2:0]      r_vcnt;
    logic            r_valid;

    // Plain flop chain, no logic between stages
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= bus.gray_in;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_gray_out = r_sync[STAGES-1];

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
    always_comb begin
        w_bin = '0;
        for (int i = 0; i < c_PW; i++) begin
            w_bin[i] = ^(w_gray_out >> i);
        end
    end

    // Decode register, previous-value history and change strobe
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_bin   <= '0;
            r_gprev <= '0;
            r_upd   <= 1'b0;
        end else begin
            r_bin   <= w_bin;
            r_gprev <= w_gray_out;
            r_upd   <= r_valid && (w_gray_out != r_gprev);
        end
    end

    // Saturating post-reset counter; valid once STAGES+1 edges have passed
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_vcnt  <= 3'd0;
            r_valid <= 1'b0;
        end else begin
            if (r_vcnt != 3'(STAGES)) begin
                r_vcnt <= r_vcnt + 3'd1;
            end
            r_valid <= (r_vcnt == 3'(STAGES));
        end
    end

    assign bus.gray_out = w_gray_out;
    assign bus.bin_out  = r_bin;
    assign bus.upd      = r_upd;
    assign bus.valid    = r_valid;

`ifdef GRAY_PTR_SYNC_CHECK_EN
    logic [c_PW-1:0] w_diff;
    logic            w_jump;
    logic            r_err;

    // More than one bit differs when clearing the lowest set bit leaves any bit set
    assign w_diff = w_gray_out ^ r_gprev;
    assign w_jump = r_valid && ((w_diff & (w_diff - c_PW'(1))) != '0);

    // Sticky jump flag; a new jump outranks a simultaneous clear
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_err <= 1'b0;
        end else if (w_jump) begin
            r_err <= 1'b1;
        end else if (bus.err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign bus.err = r_err;
`else
    logic w_unused_err_clr;

    assign w_unused_err_clr = bus.err_clr;
    assign bus.err          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gray_ptr_sync.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gray_ptr_sync
//  Purpose  : Self-checking bench for gray_ptr_sync, STAGES=2 and STAGES=3
//             instances driven by the same stimulus and compared every cycle
//             against a history-based model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gray_ptr_sync;

    localparam int W    = 6;
    localparam int HMAX = 4096;

`ifdef GRAY_PTR_SYNC_CHECK_EN
    localparam bit c_CHK = 1'b1;
`else
    localparam bit c_CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstn;
    logic [W:0] gray_in;
    logic       err_clr;

    int total = 0;
    int bad   = 0;
    int upd_cnt = 0;
    bit count_en = 1'b0;

    gray_ptr_sync_if #(.WIDTH(W)) bus2 ();
    gray_ptr_sync_if #(.WIDTH(W)) bus3 ();

    assign bus2.gray_in = gray_in;
    assign bus2.err_clr = err_clr;
    assign bus3.gray_in = gray_in;
    assign bus3.err_clr = err_clr;

    gray_ptr_sync #(.WIDTH(W), .STAGES(2)) u2 (.clk(clk), .rstn(rstn), .bus(bus2.slave));
    gray_ptr_sync #(.WIDTH(W), .STAGES(3)) u3 (.clk(clk), .rstn(rstn), .bus(bus3.slave));

    always #5 clk = ~clk;

    function automatic logic [W:0] to_gray(int b);
        logic [W:0] v;
        v = b[W:0];
        return v ^ (v >> 1);
    endfunction

    function automatic logic [W:0] to_bin(logic [W:0] g);
        logic [W:0] b;
        b = g;
        b = b ^ (b >> 1);
        b = b ^ (b >> 2);
        b = b ^ (b >> 4);
        return b;
    endfunction

    task automatic chk(string name, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (input history based) -------------
    logic [W:0] h_gin  [HMAX];
    bit         h_rst  [HMAX];
    bit         h_clr  [HMAX];
    logic [W:0] m_gout [2][HMAX];
    logic [W:0] m_bin  [2][HMAX];
    bit         m_val  [2][HMAX];
    bit         m_err  [2][HMAX];
    int         m_rel  [2][HMAX];
    int         n = 1;

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 2; j++) begin
                m_gout[k][j] = '0; m_bin[k][j] = '0;
                m_val[k][j] = 1'b0; m_err[k][j] = 1'b0; m_rel[k][j] = 0;
            end
        end
    end

    // Record inputs at each edge, derive expected outputs, compare 1ns later
    always @(posedge clk) begin
        int         s, rel;
        logic [W:0] eg, eb;
        bit         ev, eu, ee, jmp;
        logic [W:0] ag, ab;
        bit         av, au, ae;
        if (n < HMAX - 1) begin
            n++;
            h_gin[n] = gray_in;
            h_rst[n] = rstn;
            h_clr[n] = err_clr;
            #1;
            for (int k = 0; k < 2; k++) begin
                s   = k + 2;
                rel = h_rst[n] ? ((m_rel[k][n-1] < 100) ? m_rel[k][n-1] + 1 : 100) : 0;
                eg  = (rel >= s) ? h_gin[n-s+1] : '0;
                eb  = h_rst[n] ? to_bin(m_gout[k][n-1]) : '0;
                ev  = (rel >= s + 1);
                eu  = h_rst[n] && m_val[k][n-1] && (eb != m_bin[k][n-1]);
                jmp = m_val[k][n-1] && ($countones(m_gout[k][n-1] ^ m_gout[k][n-2]) > 1);
                ee  = c_CHK && h_rst[n] && (jmp || (m_err[k][n-1] && !h_clr[n]));
                m_rel[k][n] = rel; m_gout[k][n] = eg; m_bin[k][n] = eb;
                m_val[k][n] = ev;  m_err[k][n]  = ee;
                ag = (k == 0) ? bus2.gray_out : bus3.gray_out;
                ab = (k == 0) ? bus2.bin_out  : bus3.bin_out;
                av = (k == 0) ? bus2.valid    : bus3.valid;
                au = (k == 0) ? bus2.upd      : bus3.upd;
                ae = (k == 0) ? bus2.err      : bus3.err;
                chk($sformatf("model s%0d gray_out", s), int'(ag), int'(eg));
                chk($sformatf("model s%0d bin_out", s),  int'(ab), int'(eb));
                chk($sformatf("model s%0d valid", s),    int'(av), int'(ev));
                chk($sformatf("model s%0d upd", s),      int'(au), int'(eu));
                chk($sformatf("model s%0d err", s),      int'(ae), int'(ee));
            end
            if (count_en && bus2.upd) upd_cnt++;
        end
    end

    // ---------------- stimulus with literal expectations -------------------
    initial begin
        int p;
        int r;
        rstn    = 1'b0;
        gray_in = 7'b0000111;
        err_clr = 1'b0;

        // Reset held for three edges
        repeat (3) @(posedge clk);
        #2;
        chk("rst gray_out", int'(bus2.gray_out), 0);
        chk("rst bin_out",  int'(bus2.bin_out), 0);
        chk("rst valid",    int'(bus2.valid), 0);
        chk("rst upd",      int'(bus2.upd), 0);
        @(negedge clk) rstn = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("s2 valid edge2", int'(bus2.valid), 0);
        @(posedge clk); #2;
        chk("s2 valid edge3", int'(bus2.valid), 1);
        chk("s2 bin edge3",   int'(bus2.bin_out), 5);
        chk("s2 upd edge3",   int'(bus2.upd), 0);
        chk("s3 valid edge3", int'(bus3.valid), 0);
        @(posedge clk); #2;
        chk("s3 valid edge4", int'(bus3.valid), 1);
        chk("s3 bin edge4",   int'(bus3.bin_out), 5);

        // Latency, STAGES=3: gray 0000111 -> 0000101 (bin 5 -> 6)
        @(negedge clk) gray_in = 7'b0000101;
        repeat (2) @(posedge clk);
        #2;
        chk("s3 lat gray e2", int'(bus3.gray_out), 7);
        @(posedge clk); #2;
        chk("s3 lat gray e3", int'(bus3.gray_out), 5);
        chk("s3 lat upd e3",  int'(bus3.upd), 0);
        @(posedge clk); #2;
        chk("s3 lat bin e4",  int'(bus3.bin_out), 6);
        chk("s3 lat upd e4",  int'(bus3.upd), 1);
        @(posedge clk); #2;
        chk("s3 lat upd e5",  int'(bus3.upd), 0);

        // Walk back to zero with legal steps, then a two-bit jump to 0000011
        @(negedge clk) gray_in = 7'b0000100;
        repeat (6) @(posedge clk);
        @(negedge clk) gray_in = 7'b0000000;
        repeat (6) @(posedge clk);
        @(negedge clk) gray_in = 7'b0000011;
        repeat (2) @(posedge clk);
        #2;
        chk("jump err e2", int'(bus2.err), 0);
        @(posedge clk); #2;
        chk("jump err e3", int'(bus2.err), int'(c_CHK));
        chk("jump bin e3", int'(bus2.bin_out), 2);
        chk("jump upd e3", int'(bus2.upd), 1);
        repeat (3) @(posedge clk);
        #2;
        chk("jump err held", int'(bus2.err), int'(c_CHK));
        @(negedge clk) err_clr = 1'b1;
        @(posedge clk); #2;
        chk("err_clr s2", int'(bus2.err), 0);
        chk("err_clr s3", int'(bus3.err), 0);
        // Second jump 0000011 -> 0000000 with err_clr high only in the set cycle
        @(negedge clk) begin err_clr = 1'b0; gray_in = 7'b0000000; end
        repeat (2) @(posedge clk);
        @(negedge clk) err_clr = 1'b1;
        @(posedge clk); #2;
        chk("set beats clr", int'(bus2.err), int'(c_CHK));
        @(negedge clk) err_clr = 1'b0;
        @(posedge clk); #2;
        chk("set beats clr held", int'(bus2.err), int'(c_CHK));

        // Count sweep 0..127 then wrap to 0
        @(negedge clk) err_clr = 1'b1;
        @(negedge clk) err_clr = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk) begin upd_cnt = 0; count_en = 1'b1; end
        for (int i = 1; i <= 128; i++) begin
            @(negedge clk) gray_in = to_gray(i % 128);
        end
        repeat (8) @(posedge clk);
        #2;
        count_en = 1'b0;
        chk("sweep upd count", upd_cnt, 128);
        chk("sweep wrap bin",  int'(bus2.bin_out), 0);
        chk("sweep wrap err",  int'(bus2.err), 0);

        // Mid-run reset for one clock while sweeping
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk) gray_in = to_gray(i);
        end
        @(negedge clk) begin gray_in = to_gray(21); rstn = 1'b0; end
        @(posedge clk); #2;
        chk("midrst gray_out", int'(bus2.gray_out), 0);
        chk("midrst bin_out",  int'(bus2.bin_out), 0);
        chk("midrst valid",    int'(bus2.valid), 0);
        chk("midrst upd",      int'(bus2.upd), 0);
        chk("midrst s3 valid", int'(bus3.valid), 0);
        @(negedge clk) begin gray_in = to_gray(22); rstn = 1'b1; end
        @(posedge clk);
        @(negedge clk) gray_in = to_gray(23);
        @(posedge clk); #2;
        chk("midrst valid e2", int'(bus2.valid), 0);
        @(negedge clk) gray_in = to_gray(24);
        @(posedge clk); #2;
        chk("midrst valid e3", int'(bus2.valid), 1);
        chk("midrst upd e3",   int'(bus2.upd), 0);

        // Randomised phase: mostly legal increments, some holds, jumps, clears, resets
        p = 24;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            r = int'($urandom_range(0, 99));
            if (r < 70)      p = (p + 1) % 128;
            else if (r < 92) p = p;
            else             p = int'($urandom_range(0, 127));
            gray_in = to_gray(p);
            err_clr = ($urandom_range(0, 19) == 0);
            rstn    = ($urandom_range(0, 59) != 0);
        end
        @(negedge clk) begin rstn = 1'b1; err_clr = 1'b0; end
        repeat (8) @(posedge clk);
        #2;
        chk("final valid", int'(bus3.valid), 1);
        chk("final bin",   int'(bus3.bin_out), int'(to_bin(gray_in)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gray_ptr_sync.md
# gray_ptr_sync

Parametrised multi-stage synchroniser for Gray-coded FIFO pointers entering the `clk` domain. It carries a `WIDTH+1`-bit pointer through `STAGES` flops and produces:
- the synchronised Gray value,
- a registered binary decode,
- a one-cycle update strobe,
- a post-reset valid flag.

It is the standard pointer-crossing element for the asynchronous FIFO family: one instance for the write pointer into the read domain, one for the read pointer into the write domain. Optionally it detects illegal multi-bit Gray jumps.

## Interface
Parameters:
- `WIDTH`, 6, pointer address width; pointer buses are `WIDTH+1` bits (extra wrap bit).
- `STAGES`, 2, synchroniser depth; legal range 2..4. Other values are an elaboration error.

Ports (clock and reset first):
- `clk`  in  1  destination-domain clock.
- `rstn`  in  1  synchronous, active-low reset.
- `gray_in`  in  WIDTH+1  Gray pointer from the foreign domain (asynchronous to `clk`).
- `err_clr`  in  1  clears the sticky `err` flag.
- `gray_out`  out  WIDTH+1  synchronised Gray pointer.
- `bin_out`  out  WIDTH+1  binary decode of `gray_out`, registered.
- `upd`  out  1  one-cycle pulse when `bin_out` takes a new value.
- `valid`  out  1  high once the pipeline holds only post-reset samples.
- `err`  out  1  sticky multi-bit-jump flag; present only with `GRAY_PTR_SYNC_CHECK_EN`, otherwise tied 0.

## Operation
- **Sync chain:** `STAGES` registers `s[0..STAGES-1]`.
  - `s[0] <= gray_in`; `s[i] <= s[i-1]`.
  - `gray_out = s[STAGES-1]`.
  - No logic between stages.
- **Decode:** `bin_out` is registered from `gray_out`.
  - `b[WIDTH] = g[WIDTH]`; `b[i] = b[i+1] ^ g[i]`.
- **Update strobe:** an internal register `gprev` holds the previous `gray_out`.
  - `upd` is registered and asserts the cycle `bin_out` changes, i.e. one cycle after `gray_out != gprev`.
- **Valid counter:** saturating counter, cleared by reset.
  - `valid` asserts after `STAGES+1` clocks with `rstn` high, then stays high.
  - `upd` and `err` are suppressed while `valid` is low.
- **Wrap-around:** the transition `1000000 -> 0000000` (WIDTH=6) is a legal single-bit change and decodes `127 -> 0`; it produces `upd`.
- **Simultaneous events:** if an `err` set condition and `err_clr` occur in the same cycle, set wins.

## Timing
- **Reset:** while `rstn` is low at a rising edge, all of the following are 0 on the next cycle and stay 0 until release:
  - all stages, `gprev`, `gray_out`, `bin_out`, `upd`, `valid`, `err`.
- **Latency:**
  - `gray_in` to `gray_out`: `STAGES` clocks.
  - `gray_in` to `bin_out` and `upd`: `STAGES+1` clocks.
- **Throughput:** a new value is accepted every cycle. Consecutive changes give back-to-back `upd` pulses.
- **Reset mid-operation:** takes effect on the next edge regardless of state. `valid` drops and its counter restarts from 0.
- **Stability:** a value on `gray_in` held steady gives `upd` exactly once.

## Configuration
Macro `GRAY_PTR_SYNC_CHECK_EN`.
- **Defined:**
  - Each cycle with `valid` high, compute `popcount(gray_out ^ gprev)`.
  - A result greater than 1 sets `err` on the next edge.
  - `err` holds until `err_clr` or reset.
- **Undefined:** no checker logic is generated and `err` is constant 0. All other behaviour is identical.

## Test plan
- **Reset/valid**, STAGES=2: hold `rstn`=0 for 3 clocks, `gray_in`=7'b0000111 -> all outputs 0 during reset; `valid` rises on the 3rd edge after release; `bin_out`=5; no `upd` before `valid`.
- **Latency**, STAGES=3: after `valid`, step `gray_in` 0000111 -> 0000101 (bin 5 -> 6) -> `gray_out` changes 3 clocks later; `bin_out`=6 and `upd`=1 for exactly one cycle at 4 clocks.
- **Count sweep:** drive binary 0..127..0 as Gray, one step per clock -> `bin_out` follows in order with 128 `upd` pulses. The wrap `1000000 -> 0000000` gives `bin_out` 127 -> 0 and `err`=0.
- **Jump error** (macro defined): after `valid`, step 0000000 -> 0000011 -> `err`=1 at `STAGES+1` clocks and held. Pulse `err_clr` -> `err`=0 next cycle. Repeating the jump with `err_clr` high in the set cycle leaves `err`=1.
- **Macro undefined:** same jump stimulus -> `err` stays 0, while `bin_out`=2 and `upd` behave normally.
- **Mid-run reset:** assert `rstn`=0 for 1 clock while sweeping -> all outputs 0 the next cycle; `valid` re-asserts `STAGES+1` clocks after release.
